imem_wb_loader: RTL
===================

# imem_wb_loader

Wishbone-slave loader that sits upstream of the SLRV instruction SRAM. It gives the management SoC write and read access to SRAM port 0, and holds the SLRV core in reset until software sets a RUN bit. It turns single classic-Wishbone cycles into one-cycle SRAM port-0 accesses through a small FSM, and keeps load and drop statistics in a status register.

## Interface
Parameters:
- BASE_ADDR, 32'h3000_0000: base of the 4 KB decode window; only bits [31:12] are compared.
- ADDR_W, 9: SRAM word-address width (512 words).

Ports (one clock; reset is synchronous and active-high):
- wb_clk_i  in  1  clock; all state changes on its rising edge.
- wb_rst_i  in  1  synchronous active-high reset.
- wbs_cyc_i, wbs_stb_i, wbs_we_i  in  1 each  classic Wishbone request.
- wbs_sel_i  in  4  byte enables.
- wbs_adr_i  in  32  byte address.
- wbs_dat_i  in  32  write data.
- wbs_dat_o  out  32  registered read data.
- wbs_ack_o  out  1  registered, one-cycle acknowledge.
- sram_csb0  out  1  port-0 chip select, active low.
- sram_web0  out  1  port-0 write enable, active low.
- sram_wmask0  out  4  byte write mask.
- sram_addr0  out  ADDR_W  word address.
- sram_din0  out  32  write data.
- sram_dout0  in  32  read data.
- core_reset_o  out  1  reset to the SLRV core; high while RUN=0.

## Operation
- Hit: wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:12]==BASE_ADDR[31:12]). On a non-hit there is no ack and no side effect.
- Window map, by offset = wbs_adr_i[11:0]:
  - 0x000–0x7FF: SRAM. Word index = adr[10:2]; adr[1:0] are ignored.
  - 0x800: CTRL (R/W). Bit0 RUN. Bit1 CLR is write-1 self-clearing and zeroes both counters. Reads return {30'b0, 1'b0, RUN}.
  - 0x804: STATUS (RO). [9:0] WORDS = SRAM writes issued, saturating at 1023. [23:16] DROPS = SRAM writes rejected, saturating at 255. Other bits read 0.
  - Any other offset: acked, reads 0, writes ignored.
- core_reset_o = ~RUN. RUN resets to 0.
- FSM states: IDLE, WR, RD, RDWAIT, ACK.
  - IDLE, SRAM write hit with RUN=0 → WR. Drive csb0=0, web0=0, addr, din=wbs_dat_i, wmask=wbs_sel_i. WORDS increments, even when sel=0.
  - IDLE, SRAM write hit with RUN=1 → ACK. No SRAM access; DROPS increments.
  - IDLE, SRAM read hit → RD. Drive csb0=0, web0=1. Allowed whatever the value of RUN.
  - IDLE, register hit → ACK. The register write or read capture happens at that edge.
  - WR → ACK.
  - RD → RDWAIT.
  - RDWAIT → ACK, capturing sram_dout0 into wbs_dat_o.
  - ACK → IDLE. wbs_ack_o=1 only in ACK.
- Outside WR/RD, csb0=1, web0=1, wmask=0. addr and din hold their last value.
- wbs_dat_o holds its last value and is only updated on read captures. Write acks leave it unchanged.
- Counters saturate; they never wrap. CLR takes priority over an increment in the same cycle. A CLR and a RUN write in the same transaction both take effect.
- Requests are evaluated only in IDLE; a request held during other states is not sampled again. A master that drops stb before its ack abandons the cycle: the FSM still completes and pulses ack once.

## Timing
- Request sampled at edge E0 (IDLE).
  - SRAM write: WR in cycle E0–E1, SRAM latches at E1, ack high in E1–E2. Latency 2 cycles.
  - SRAM read: RD in E0–E1, SRAM launches dout after E1, captured at E2, ack and data valid in E2–E3. Latency 3 cycles.
  - Register access or dropped write: ack in E0–E1. Latency 1 cycle.
- Back-to-back requests: minimum spacing is ack cycle + 1, since IDLE must be re-entered.
- Reset values while wb_rst_i=1 and after:
  - state IDLE, wbs_ack_o=0, wbs_dat_o=0;
  - sram_csb0=1, sram_web0=1, sram_wmask0=0, sram_addr0=0, sram_din0=0;
  - RUN=0, core_reset_o=1, WORDS=0, DROPS=0.
- Reset during WR, RD or RDWAIT aborts the access. No ack is issued and csb0 returns to 1 in the next cycle.

## Test plan
- Reset, then write 0xDEADBEEF to BASE+0x010 with sel=4'hF → csb0=0, web0=0, addr0=4, wmask0=F for exactly one cycle; ack 2 cycles after request; STATUS reads 0x0000_0001.
- Read back BASE+0x010 with the SRAM model returning 0xDEADBEEF → ack 3 cycles after request; wbs_dat_o=0xDEADBEEF; web0 stays 1.
- Write CTRL=1 → core_reset_o falls the cycle after the edge where the CTRL hit is sampled. A following SRAM write → ack in 1 cycle, csb0 stays 1, STATUS=0x0001_0001.
- 1030 SRAM writes with RUN=0, then write CTRL=2 → WORDS reads 1023 before the CLR and STATUS=0 after it.
- Access to 0x3000_1000 → no ack, no csb0. Read of BASE+0x900 → ack in 1 cycle, data 0.
- Assert wb_rst_i during RDWAIT → no ack, csb0=1, core_reset_o=1, STATUS=0 afterwards.

Source files
------------

// File: rtl/imem_wb_loader.sv
// imem_wb_loader
// Classic Wishbone slave that lets the management SoC load and inspect the
// SLRV instruction SRAM through port 0, holds the core in reset until RUN
// is set, and counts accepted and rejected SRAM writes.
module imem_wb_loader #(
  parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
  parameter int          ADDR_W    = 9
) (
  input  logic              wb_clk_i,
  input  logic              wb_rst_i,
  input  logic              wbs_cyc_i,
  input  logic              wbs_stb_i,
  input  logic              wbs_we_i,
  input  logic [3:0]        wbs_sel_i,
  input  logic [31:0]       wbs_adr_i,
  input  logic [31:0]       wbs_dat_i,
  output logic [31:0]       wbs_dat_o,
  output logic              wbs_ack_o,
  output logic              sram_csb0,
  output logic              sram_web0,
  output logic [3:0]        sram_wmask0,
  output logic [ADDR_W-1:0] sram_addr0,
  output logic [31:0]       sram_din0,
  input  logic [31:0]       sram_dout0,
  output logic              core_reset_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_WR,
    S_RD,
    S_RDWAIT,
    S_ACK
  } state_t;

  localparam logic [11:0] OFF_CTRL   = 12'h800;
  localparam logic [11:0] OFF_STATUS = 12'h804;
  localparam logic [9:0]  WORDS_MAX  = 10'd1023;
  localparam logic [7:0]  DROPS_MAX  = 8'd255;

  state_t      state, state_nx;
  logic        run;
  logic [9:0]  words;
  logic [7:0]  drops;
  logic [3:0]  wmask_q;
  logic [31:0] reg_rdata;

  // Request decode; only meaningful while IDLE, since requests are never
  // re-sampled once an access is in flight.
  logic [11:0] offset;
  logic        hit, accept, is_sram;
  logic        sram_wr_go, sram_rd_go, drop_go, reg_go, ctrl_wr, clr;

  assign offset     = wbs_adr_i[11:0];
  assign hit        = wbs_cyc_i & wbs_stb_i & (wbs_adr_i[31:12] == BASE_ADDR[31:12]);
  assign accept     = (state == S_IDLE) & hit;
  assign is_sram    = ~offset[11];
  assign sram_wr_go = accept & is_sram & wbs_we_i & ~run;
  assign drop_go    = accept & is_sram & wbs_we_i & run;
  assign sram_rd_go = accept & is_sram & ~wbs_we_i;
  assign reg_go     = accept & ~is_sram;
  assign ctrl_wr    = reg_go & wbs_we_i & (offset == OFF_CTRL);
  assign clr        = ctrl_wr & wbs_dat_i[1];

  assign core_reset_o = ~run;

  // Register read mux; unmapped offsets in the register half read as zero.
  always_comb begin
    reg_rdata = '0;
    if (offset == OFF_CTRL) begin
      reg_rdata = {30'b0, 1'b0, run};
    end else if (offset == OFF_STATUS) begin
      reg_rdata = {8'b0, drops, 6'b0, words};
    end
  end

  // State register; a reset in WR/RD/RDWAIT simply abandons the access.
  always_ff @(posedge wb_clk_i) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (wb_rst_i) state <= S_IDLE;
    else          state <= state_nx;
  end

  // Next-state logic and the SRAM strobes, which are pure decodes of state.
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    state_nx    = state;
    sram_csb0   = 1'b1;
    sram_web0   = 1'b1;
    sram_wmask0 = 4'h0;
    wbs_ack_o   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (sram_wr_go)              state_nx = S_WR;
        else if (sram_rd_go)         state_nx = S_RD;
        else if (drop_go || reg_go)  state_nx = S_ACK;
      end
      S_WR: begin
        sram_csb0   = 1'b0;
        sram_web0   = 1'b0;
        sram_wmask0 = wmask_q;
        state_nx    = S_ACK;
      end
      S_RD: begin
        sram_csb0 = 1'b0;
        state_nx  = S_RDWAIT;
      end
      S_RDWAIT: state_nx = S_RDWAIT == state ? S_ACK : S_IDLE;
      S_ACK: begin
        wbs_ack_o = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

  // SRAM address/data/mask are captured when an access is accepted and then
  // held, so the port sees stable values for the whole WR or RD cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      sram_addr0 <= '0;
      sram_din0  <= '0;
      wmask_q    <= '0;
    end else begin
      if (sram_wr_go || sram_rd_go) sram_addr0 <= wbs_adr_i[ADDR_W+1:2];
      if (sram_wr_go) begin
        sram_din0 <= wbs_dat_i;
        wmask_q   <= wbs_sel_i;
      end
    end
  end

  // CTRL and statistics; CLR wins over any increment in the same cycle.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      run   <= 1'b0;
      words <= '0;
      drops <= '0;
    end else begin
      if (ctrl_wr) run <= wbs_dat_i[0];
      if (clr) begin
        words <= '0;
        drops <= '0;
      end else begin
        if (sram_wr_go && words != WORDS_MAX) words <= words + 10'd1;
        if (drop_go && drops != DROPS_MAX)    drops <= drops + 8'd1;
      end
    end
  end

  // Read data: SRAM data lands on leaving RDWAIT, register reads on accept.
  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      wbs_dat_o <= '0;
    end else if (state == S_RDWAIT) begin
      wbs_dat_o <= sram_dout0;
    end else if (reg_go && !wbs_we_i) begin
      wbs_dat_o <= reg_rdata;
    end
  end

endmodule
